// File: rtl/seq_mult_add.sv
// Sequential 4x4 shift-add multiplier followed by a 9-bit add of a captured addend.
// Fixed latency: load pulses five cycles after the start-capture edge.
module seq_mult_add (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [8:0] acc_in,
   output logic       busy,
   output logic       load,
   output logic [8:0] sum_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t     state;
   logic [7:0] mcand;
   logic [3:0] mplier;
   logic [8:0] acc_q;
   logic [7:0] prod;
   logic [1:0] step;

   // NOTE: all state lives in one clocked block with non-blocking assignments so every
   // register samples pre-edge values; the async reset clears datapath registers as well.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mcand   <= '0;
         mplier  <= '0;
         acc_q   <= '0;
         prod    <= '0;
         step    <= '0;
         busy    <= 1'b0;
         load    <= 1'b0;
         sum_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {4'b0000, a};
                  mplier <= b;
                  acc_q  <= acc_in;
                  prod   <= '0;
                  step   <= '0;
                  busy   <= 1'b1;
                  state  <= MUL;
               end
            end
            MUL: begin
               // product never exceeds 225, so the 8-bit partial sum cannot carry out
               if (mplier[0]) prod <= prod + mcand;
               mplier <= mplier >> 1;
               mcand  <= mcand << 1;
               step   <= step + 2'd1;
               if (step == 2'd3) state <= ADD;
            end
            ADD: begin
               sum_out <= acc_q + {1'b0, prod};
               load    <= 1'b1;
               state   <= OUT;
            end
            OUT: begin
               load  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/seq_mult_add.md
SEQ_MULT_ADD -- requirements
Module: seq_mult_add

Interface
REQ-001 Parameters: none; operand widths are fixed at 4-bit multiplicand/multiplier and 9-bit accumulate path.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one multiply-add operation; sampled on posedge clk.
REQ-005 a  input  4  unsigned multiplicand.
REQ-006 b  input  4  unsigned multiplier.
REQ-007 acc_in  input  9  unsigned addend, the running value fed back from the downstream accumulator.
REQ-008 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-009 load  output  1  single-cycle strobe marking sum_out valid; drives the downstream accumulator load.
REQ-010 sum_out  output  9  result acc_in + a*b, modulo 512.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, MUL, ADD, OUT.
REQ-012 In IDLE, start=1 at posedge N SHALL capture a, b and acc_in into internal registers, clear the partial product and step counter, and enter MUL.
REQ-013 start SHALL be ignored in every state other than IDLE; no queuing.
REQ-014 Changes on a, b or acc_in after the capture edge SHALL NOT affect the result in progress.
REQ-015 In MUL, each posedge SHALL perform one shift-add step: if the captured multiplier LSB is 1, add the shifted multiplicand to the 8-bit partial product; shift the multiplier right and the multiplicand left by one bit.
REQ-016 MUL SHALL last exactly 4 cycles (edges N+1..N+4), with a 2-bit step counter; MUL SHALL transition to ADD at edge N+4.
REQ-017 Product width: the 8-bit product (maximum 225) SHALL NOT overflow.
REQ-018 At edge N+5, ADD SHALL register sum_out = captured acc_in + product, truncated to 9 bits (carry discarded), and enter OUT.
REQ-019 load SHALL be 1 only while in OUT: high from edge N+5 to edge N+6, exactly one cycle per operation.
REQ-020 OUT SHALL return to IDLE unconditionally at edge N+6; the earliest accepted next start is at edge N+7.
REQ-021 busy SHALL be high from edge N through edge N+6, including the OUT cycle.
REQ-022 sum_out SHALL hold its value until the next ADD state overwrites it.
REQ-023 Zero operands (a=0 or b=0) SHALL take the full fixed latency; sum_out then equals the captured acc_in.
REQ-024 Latency SHALL be data-independent: load asserts 5 cycles after the start-capture edge for every operand value.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE; busy=0, load=0, sum_out=0; internal operand, product and counter registers SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL abort it with no load pulse; the aborted result SHALL never appear on sum_out.
REQ-027 start asserted while rst=1 SHALL be ignored; the first accepted start is the first posedge with rst=0.

Verification
REQ-028 Assert rst -> busy=0, load=0, sum_out=0; after release with start=0, the block stays idle and all outputs remain 0.
REQ-029 a=3, b=5, acc_in=0, start pulsed at edge N -> load=1 for one cycle after edge N+5, sum_out=15, busy=0 after edge N+6.
REQ-030 a=15, b=15, acc_in=400 -> sum_out=113 (625 mod 512), with a single load pulse.
REQ-031 a=2, b=7, acc_in=10, start, then at edge N+2 start=1 with a=9, b=9 -> sum_out=24, exactly one load pulse, second request dropped.
REQ-032 a=6, b=6, acc_in=1, start, rst pulsed at edge N+3 -> no load pulse, sum_out=0; a following start with a=1, b=1, acc_in=1 -> sum_out=2.
REQ-033 a=0, b=13, acc_in=300 -> sum_out=300, load after edge N+5; operand inputs changed after edge N leave the result unchanged.
